// File: rtl/pong_game_engine.sv
// pong_game_engine -- per-frame game state for Pong: ball, paddles, scores and
// the IDLE/SERVE/PLAY/OVER sequencing. Produces coordinates and status only.
//
// Ports:
//   clk_100MHz         system clock
//   reset              synchronous, active-high
//   frame_tick         one-clock pulse per video frame; all motion steps on it
//   up[1:0], down[1:0] bit0 = right player, bit1 = left player (debounced levels)
//   serve              debounced level, rising edge starts/restarts play
//   ball_x, ball_y     ball top-left corner
//   pad_r_y, pad_l_y   paddle top rows
//   score_r, score_l   player scores
//   state              0 IDLE, 1 SERVE, 2 PLAY, 3 OVER
//   game_over          high while in OVER
//   hit_pulse          one clock on a paddle hit
//   miss_pulse         one clock on a point scored
module pong_game_engine #(
   parameter int H_PIX       = 640,
   parameter int V_PIX       = 480,
   parameter int PLAYERS     = 2,
   parameter int PAD_H       = 72,
   parameter int PAD_W       = 4,
   parameter int PAD_L_X     = 32,
   parameter int PAD_R_X     = 600,
   parameter int PAD_V       = 3,
   parameter int BALL_SZ     = 8,
   parameter int BALL_V      = 2,
   parameter int MAX_SCORE   = 7,
   parameter int SERVE_DELAY = 60
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [1:0] up,
   input  logic [1:0] down,
   input  logic       serve,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [9:0] pad_r_y,
   output logic [9:0] pad_l_y,
   output logic [3:0] score_r,
   output logic [3:0] score_l,
   output logic [1:0] state,
   output logic       game_over,
   output logic       hit_pulse,
   output logic       miss_pulse
);

   typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

   localparam int CNT_W = $clog2(SERVE_DELAY + 1);

   localparam logic [9:0] BALL_X0 = 10'(H_PIX / 2 - BALL_SZ / 2);
   localparam logic [9:0] BALL_Y0 = 10'(V_PIX / 2 - BALL_SZ / 2);
   localparam logic [9:0] PAD_Y0  = 10'((V_PIX - PAD_H) / 2);
   localparam logic [9:0] PAD_MAX = 10'(V_PIX - PAD_H);
   localparam logic [9:0] PAD_STP = 10'(PAD_V);
   localparam logic [9:0] Y_BOT   = 10'(V_PIX - BALL_SZ);
   localparam logic [9:0] X_HIT_R = 10'(PAD_R_X - BALL_SZ);
   localparam logic [9:0] X_HIT_L = 10'(PAD_L_X + PAD_W);
   localparam logic [3:0] WIN     = 4'(MAX_SCORE);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_DELAY);

   // Signed 11-bit copies so stepping past 0 or past the right edge never wraps.
   localparam logic signed [10:0] S_BV     = 11'(BALL_V);
   localparam logic signed [10:0] S_BS     = 11'(BALL_SZ);
   localparam logic signed [10:0] S_PH     = 11'(PAD_H);
   localparam logic signed [10:0] S_Y_MAX  = 11'(V_PIX - BALL_SZ);
   localparam logic signed [10:0] S_X_MAX  = 11'(H_PIX - BALL_SZ);
   localparam logic signed [10:0] S_R_FACE = 11'(PAD_R_X);
   localparam logic signed [10:0] S_L_FACE = 11'(PAD_L_X + PAD_W);

   state_t           st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dx_q, dx_d;   // 1 = moving right
   logic             dy_q, dy_d;   // 1 = moving down
   logic             serve_q, serve_edge;

   logic [9:0] bx_d, by_d, pr_d, pl_d;
   logic [3:0] sr_d, sl_d, sr_inc, sl_inc;
   logic       hit_d, miss_d;

   logic signed [10:0] bx_s, by_s, pr_s, pl_s, nx_c, ny_c;
   logic [9:0] x_play, y_play;
   logic       dx_play, dy_play, hit_c, pt_l, pt_r, win_c;

   assign serve_edge = serve & ~serve_q;
   assign state      = st_q;

   assign bx_s = $signed({1'b0, ball_x});
   assign by_s = $signed({1'b0, ball_y});
   assign pr_s = $signed({1'b0, pad_r_y});
   assign pl_s = $signed({1'b0, pad_l_y});

   assign sr_inc = (score_r == 4'd15) ? 4'd15 : score_r + 4'd1;
   assign sl_inc = (score_l == 4'd15) ? 4'd15 : score_l + 4'd1;
   assign win_c  = pt_l ? (sl_inc == WIN) : (sr_inc == WIN);

   function automatic logic [9:0] pad_step(input logic [9:0] y, input logic u, input logic d);
      pad_step = y;
      if (u && !d)
         pad_step = (y < PAD_STP) ? 10'd0 : y - PAD_STP;
      else if (d && !u)
         pad_step = (y > PAD_MAX - PAD_STP) ? PAD_MAX : y + PAD_STP;
   endfunction

   // Ball physics for one PLAY frame, evaluated every clock; only used on a tick.
   // Paddle overlap uses the paddle position before this frame's paddle move.
   always_comb begin
      nx_c    = dx_q ? bx_s + S_BV : bx_s - S_BV;
      ny_c    = dy_q ? by_s + S_BV : by_s - S_BV;
      y_play  = ny_c[9:0];
      dy_play = dy_q;
      if (ny_c < 11'sd0) begin
         y_play  = 10'd0;
         dy_play = 1'b1;
      end else if (ny_c > S_Y_MAX) begin
         y_play  = Y_BOT;
         dy_play = 1'b0;
      end
      x_play  = nx_c[9:0];
      dx_play = dx_q;
      hit_c   = 1'b0;
      if (dx_q && (bx_s + S_BS <= S_R_FACE) && (nx_c + S_BS >= S_R_FACE) &&
          (by_s + S_BS > pr_s) && (by_s < pr_s + S_PH)) begin
         x_play  = X_HIT_R;
         dx_play = 1'b0;
         hit_c   = 1'b1;
      end
      if (PLAYERS == 2) begin
         if (!dx_q && (bx_s >= S_L_FACE) && (nx_c <= S_L_FACE) &&
             (by_s + S_BS > pl_s) && (by_s < pl_s + S_PH)) begin
            x_play  = X_HIT_L;
            dx_play = 1'b1;
            hit_c   = 1'b1;
         end
      end else if (nx_c < 11'sd0) begin
         // single player: left edge is a plain wall
         x_play  = 10'd0;
         dx_play = 1'b1;
      end
      pt_l = (nx_c > S_X_MAX);
      pt_r = (PLAYERS == 2) && (nx_c < 11'sd0);
   end

   // Next-state logic
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
         IDLE:  if (serve_edge) begin
                   st_d  = SERVE;
                   cnt_d = CNT_LOAD;
                end
         SERVE: if (frame_tick) begin
                   if (cnt_q == CNT_W'(1)) st_d = PLAY;
                   else                    cnt_d = cnt_q - CNT_W'(1);
                end
         PLAY:  if (frame_tick && (pt_l || pt_r)) begin
                   st_d  = win_c ? OVER : SERVE;
                   cnt_d = CNT_LOAD;
                end
         OVER:  if (serve_edge) begin
                   st_d  = SERVE;
                   cnt_d = CNT_LOAD;
                end
         default: ;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      bx_d   = ball_x;
      by_d   = ball_y;
      dx_d   = dx_q;
      dy_d   = dy_q;
      sr_d   = score_r;
      sl_d   = score_l;
      pr_d   = pad_r_y;
      pl_d   = pad_l_y;
      hit_d  = 1'b0;
      miss_d = 1'b0;
      if (frame_tick && st_q != OVER) begin
         pr_d = pad_step(pad_r_y, up[0], down[0]);
         if (PLAYERS == 2) pl_d = pad_step(pad_l_y, up[1], down[1]);
      end
      case (st_q)
         PLAY: if (frame_tick) begin
                  if (pt_l || pt_r) begin
                     miss_d = 1'b1;
                     bx_d   = BALL_X0;
                     by_d   = BALL_Y0;
                     dx_d   = pt_l;     // serve toward whoever conceded
                     if (pt_l) sl_d = sl_inc;
                     else      sr_d = sr_inc;
                  end else begin
                     bx_d  = x_play;
                     by_d  = y_play;
                     dx_d  = dx_play;
                     dy_d  = dy_play;
                     hit_d = hit_c;
                  end
               end
         OVER: if (serve_edge) begin
                  sl_d = 4'd0;
                  sr_d = 4'd0;
                  bx_d = BALL_X0;
                  by_d = BALL_Y0;
                  dx_d = 1'b1;
                  dy_d = 1'b1;
               end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         st_q       <= IDLE;
         cnt_q      <= '0;
         dx_q       <= 1'b1;
         dy_q       <= 1'b1;
         serve_q    <= 1'b0;
         ball_x     <= BALL_X0;
         ball_y     <= BALL_Y0;
         pad_r_y    <= PAD_Y0;
         pad_l_y    <= PAD_Y0;
         score_r    <= 4'd0;
         score_l    <= 4'd0;
         game_over  <= 1'b0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         serve_q    <= serve;
         ball_x     <= bx_d;
         ball_y     <= by_d;
         pad_r_y    <= pr_d;
         pad_l_y    <= pl_d;
         score_r    <= sr_d;
         score_l    <= sl_d;
         game_over  <= (st_d == OVER);
         hit_pulse  <= hit_d;
         miss_pulse <= miss_d;
      end
   end

endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine. Three instances share one stimulus stream:
//   0: defaults, 1: MAX_SCORE = 1, 2: PLAYERS = 1.
// A frame-level model of each runs alongside and is compared every clock;
// directed literal checks pin the model at the interesting frames.
module tb_pong_game_engine;

   logic       clk_100MHz = 1'b0;
   logic       reset, frame_tick, serve;
   logic [1:0] up, down;

   logic [9:0] bx_o[3], by_o[3], pr_o[3], pl_o[3];
   logic [3:0] sr_o[3], sl_o[3];
   logic [1:0] st_o[3];
   logic       go_o[3], hit_o[3], miss_o[3];

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk_100MHz = ~clk_100MHz;

   pong_game_engine u_dut0 (
      .clk_100MHz(clk_100MHz), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
      .serve(serve), .ball_x(bx_o[0]), .ball_y(by_o[0]), .pad_r_y(pr_o[0]), .pad_l_y(pl_o[0]),
      .score_r(sr_o[0]), .score_l(sl_o[0]), .state(st_o[0]), .game_over(go_o[0]),
      .hit_pulse(hit_o[0]), .miss_pulse(miss_o[0]));

   pong_game_engine #(.MAX_SCORE(1)) u_dut1 (
      .clk_100MHz(clk_100MHz), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
      .serve(serve), .ball_x(bx_o[1]), .ball_y(by_o[1]), .pad_r_y(pr_o[1]), .pad_l_y(pl_o[1]),
      .score_r(sr_o[1]), .score_l(sl_o[1]), .state(st_o[1]), .game_over(go_o[1]),
      .hit_pulse(hit_o[1]), .miss_pulse(miss_o[1]));

   pong_game_engine #(.PLAYERS(1)) u_dut2 (
      .clk_100MHz(clk_100MHz), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
      .serve(serve), .ball_x(bx_o[2]), .ball_y(by_o[2]), .pad_r_y(pr_o[2]), .pad_l_y(pl_o[2]),
      .score_r(sr_o[2]), .score_l(sl_o[2]), .state(st_o[2]), .game_over(go_o[2]),
      .hit_pulse(hit_o[2]), .miss_pulse(miss_o[2]));

   // ---------------- frame-level model ----------------
   typedef struct {
      int bx, by, pr, pl, sr, sl, st, cnt, dxr, dyd, sq, hit, miss;
   } mst_t;

   mst_t m[3];

   function automatic mst_t mreset();
      mst_t r;
      r.bx = 316; r.by = 236; r.pr = 204; r.pl = 204; r.sr = 0; r.sl = 0;
      r.st = 0; r.cnt = 0; r.dxr = 1; r.dyd = 1; r.sq = 0; r.hit = 0; r.miss = 0;
      return r;
   endfunction

   function automatic int padmv(int y, bit u, bit d);
      if (u && !d) return (y - 3 < 0) ? 0 : y - 3;
      if (d && !u) return (y + 3 > 408) ? 408 : y + 3;
      return y;
   endfunction

   function automatic mst_t mstep(mst_t s, int players, int maxs, bit rst, bit tk,
                                  bit [1:0] u, bit [1:0] d, bit sv);
      mst_t n;
      bit   edge_s, won;
      int   nx, ny;
      if (rst) return mreset();
      n = s; n.hit = 0; n.miss = 0;
      edge_s = sv && (s.sq == 0);
      n.sq = sv;
      if (tk && s.st != 3) begin
         n.pr = padmv(s.pr, u[0], d[0]);
         if (players == 2) n.pl = padmv(s.pl, u[1], d[1]);
      end
      case (s.st)
         0: if (edge_s) begin n.st = 1; n.cnt = 60; end
         1: if (tk) begin
               if (s.cnt == 1) n.st = 2;
               else n.cnt = s.cnt - 1;
            end
         2: if (tk) begin
               nx = s.bx + (s.dxr != 0 ? 2 : -2);
               ny = s.by + (s.dyd != 0 ? 2 : -2);
               n.bx = nx; n.by = ny;
               if (ny < 0)        begin n.by = 0;   n.dyd = 1; end
               else if (ny > 472) begin n.by = 472; n.dyd = 0; end
               if (s.dxr != 0 && s.bx + 8 <= 600 && nx + 8 >= 600 &&
                   s.by + 8 > s.pr && s.by < s.pr + 72) begin
                  n.bx = 592; n.dxr = 0; n.hit = 1;
               end
               if (players == 2) begin
                  if (s.dxr == 0 && s.bx >= 36 && nx <= 36 &&
                      s.by + 8 > s.pl && s.by < s.pl + 72) begin
                     n.bx = 36; n.dxr = 1; n.hit = 1;
                  end
               end else if (nx < 0) begin
                  n.bx = 0; n.dxr = 1;
               end
               if (nx > 632 || (players == 2 && nx < 0)) begin
                  n.hit = 0; n.miss = 1; n.bx = 316; n.by = 236; n.dyd = s.dyd;
                  if (nx > 632) begin
                     n.dxr = 1; n.sl = (s.sl >= 15) ? 15 : s.sl + 1; won = (n.sl == maxs);
                  end else begin
                     n.dxr = 0; n.sr = (s.sr >= 15) ? 15 : s.sr + 1; won = (n.sr == maxs);
                  end
                  n.st = won ? 3 : 1; n.cnt = 60;
               end
            end
         3: if (edge_s) begin
               n.sl = 0; n.sr = 0; n.bx = 316; n.by = 236; n.dxr = 1; n.dyd = 1;
               n.st = 1; n.cnt = 60;
            end
         default: ;
      endcase
      return n;
   endfunction

   function automatic logic [61:0] mpack(mst_t s);
      return {10'(s.bx), 10'(s.by), 10'(s.pr), 10'(s.pl), 4'(s.sr), 4'(s.sl),
              2'(s.st), 1'(s.st == 3), 1'(s.hit), 1'(s.miss)};
   endfunction

   always @(posedge clk_100MHz) begin
      m[0] <= mstep(m[0], 2, 7, reset, frame_tick, up, down, serve);
      m[1] <= mstep(m[1], 2, 1, reset, frame_tick, up, down, serve);
      m[2] <= mstep(m[2], 1, 7, reset, frame_tick, up, down, serve);
   end

   // Cycle-by-cycle comparison, away from the active edge
   always @(negedge clk_100MHz) begin
      if (cmp_en) begin
         for (int i = 0; i < 3; i++) begin
            logic [61:0] act, exp;
            act = {bx_o[i], by_o[i], pr_o[i], pl_o[i], sr_o[i], sl_o[i], st_o[i],
                   go_o[i], hit_o[i], miss_o[i]};
            exp = mpack(m[i]);
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL model_cmp inst%0d t=%0t: got {bx,by,pr,pl,sr,sl,st,go,hit,miss}=%h expected %h",
                        i, $time, act, exp);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_100MHz) frame_tick = 1'b1;
      @(negedge clk_100MHz) frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic serve_pulse();
      @(negedge clk_100MHz) serve = 1'b1;
      @(negedge clk_100MHz);
      @(negedge clk_100MHz) serve = 1'b0;
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; serve = 1'b0; up = 2'b00; down = 2'b00;
      repeat (2) @(negedge clk_100MHz);
      cmp_en = 1'b1;
      reset  = 1'b0;

      // reset values
      chk("rst_ball_x", bx_o[0], 316);
      chk("rst_ball_y", by_o[0], 236);
      chk("rst_pad_r",  pr_o[0], 204);
      chk("rst_pad_l",  pl_o[0], 204);
      chk("rst_scores", {sr_o[0], sl_o[0]}, 0);
      chk("rst_state",  st_o[0], 0);
      chk("rst_over",   go_o[0], 0);

      // serve and countdown
      serve_pulse();
      chk("serve_state", st_o[0], 1);
      ticks(59);
      chk("cd59_state", st_o[0], 1);
      tick();
      chk("cd60_state", st_o[0], 2);
      chk("cd60_ball_x", bx_o[0], 316);

      // free flight to the bottom wall
      ticks(118);
      chk("p118_ball_y", by_o[0], 472);
      tick();
      chk("p119_ball_y", by_o[0], 472);
      tick();
      chk("p120_ball_y", by_o[0], 470);

      // right paddle at 204 is missed, left player scores
      ticks(38);
      chk("p158_ball_x", bx_o[0], 632);
      tick();
      chk("miss_pulse", miss_o[0], 1);
      chk("miss_score_l", sl_o[0], 1);
      chk("miss_ball_x", bx_o[0], 316);
      chk("miss_ball_y", by_o[0], 236);
      chk("miss_state", st_o[0], 1);
      chk("max1_state", st_o[1], 3);
      chk("max1_over", go_o[1], 1);
      @(negedge clk_100MHz);
      chk("miss_pulse_clear", miss_o[0], 0);

      // paddles freeze in OVER but not in SERVE
      down = 2'b01;
      ticks(10);
      chk("over_pad_frozen", pr_o[1], 204);
      chk("serve_pad_moves", pr_o[0], 234);
      down = 2'b00;
      serve_pulse();
      chk("over_serve_state", st_o[1], 1);
      chk("over_serve_score", sl_o[1], 0);
      chk("over_serve_go", go_o[1], 0);
      chk("serve_ignored", st_o[0], 1);

      // back into PLAY, then reset mid-game
      ticks(55);
      chk("replay_state", st_o[0], 2);
      @(negedge clk_100MHz) reset = 1'b1;
      @(negedge clk_100MHz);
      chk("mid_rst_state", st_o[0], 0);
      chk("mid_rst_ball_x", bx_o[0], 316);
      chk("mid_rst_ball_y", by_o[0], 236);
      chk("mid_rst_pad_r", pr_o[0], 204);
      chk("mid_rst_score_l", sl_o[0], 0);
      reset = 1'b0;

      // right paddle held down to its stop
      down = 2'b01;
      ticks(68);
      chk("pad_r_max", pr_o[0], 408);
      ticks(2);
      chk("pad_r_sat", pr_o[0], 408);

      serve_pulse();
      ticks(60);
      chk("r2_state", st_o[0], 2);
      ticks(137);
      chk("p137_ball_x", bx_o[0], 590);
      chk("p137_hit", hit_o[0], 0);
      tick();
      chk("p138_ball_x", bx_o[0], 592);
      chk("p138_hit", hit_o[0], 1);
      chk("p138_hit_p1", hit_o[2], 1);
      @(negedge clk_100MHz);
      chk("hit_clear", hit_o[0], 0);

      // single player: ball runs back to the left wall while up[1] toggles
      for (int k = 1; k <= 296; k++) begin
         up = {1'(k & 1), 1'b0};
         tick();
      end
      up = 2'b00;
      chk("p1_wall_reach", bx_o[2], 0);
      tick();
      chk("p1_wall_x", bx_o[2], 0);
      chk("p1_wall_nomiss", miss_o[2], 0);
      chk("p1_wall_state", st_o[2], 2);
      chk("p1_pad_l", pl_o[2], 204);
      tick();
      chk("p1_wall_rebound", bx_o[2], 2);

      repeat (2) @(negedge clk_100MHz);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
